// File: rtl/uart_cmd_pkg.sv
// rtl/uart_cmd_pkg.sv - shared constants and encodings for the UART time/alarm command parser
package uart_cmd_pkg;

  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_LF    = 8'h0A;
  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam logic [7:0] ASCII_T_UP  = 8'h54;
  localparam logic [7:0] ASCII_T_LO  = 8'h74;
  localparam logic [7:0] ASCII_A_UP  = 8'h41;
  localparam logic [7:0] ASCII_A_LO  = 8'h61;
  localparam logic [7:0] ASCII_0     = 8'h30;
  localparam logic [7:0] ASCII_9     = 8'h39;

  typedef enum logic [1:0] {
    ERR_UNKNOWN_CMD   = 2'd0,
    ERR_BAD_CHAR      = 2'd1,
    ERR_RANGE         = 2'd2,
    ERR_FRAME_TIMEOUT = 2'd3
  } err_code_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DIGITS = 2'd1,
    ST_TERM   = 2'd2
  } state_e;

endpackage

// File: rtl/bcd_time_range_check.sv
// rtl/bcd_time_range_check.sv - combinational range check of packed BCD hh:mm[:ss] digits
module bcd_time_range_check (
  input  logic [23:0] digits,
  input  logic        is_alarm,
  output logic        range_ok
);

  logic [3:0] h_tens, h_units, m_tens, s_tens;

  // An alarm only shifts in four digits, so its hh:mm sits in the low 16 bits.
  always_comb begin
    h_tens   = is_alarm ? digits[15:12] : digits[23:20];
    h_units  = is_alarm ? digits[11:8]  : digits[19:16];
    m_tens   = is_alarm ? digits[7:4]   : digits[15:12];
    s_tens   = digits[7:4];
    range_ok = (h_tens <= 4'd2) && ((h_tens != 4'd2) || (h_units <= 4'd3)) &&
               (m_tens <= 4'd5) && (is_alarm || (s_tens <= 4'd5));
  end

endmodule

// File: rtl/uart_time_cmd_parser.sv
// rtl/uart_time_cmd_parser.sv - parses ASCII 'Thhmmss' / 'Ahhmm' commands into BCD commit pulses
module uart_time_cmd_parser
  import uart_cmd_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 50_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  input  logic       framing_error,
  output logic [7:0] hours_bcd,
  output logic [7:0] minutes_bcd,
  output logic [7:0] seconds_bcd,
  output logic       set_time,
  output logic       set_alarm,
  output logic       cmd_error,
  output logic [1:0] err_code,
  output logic       busy
);

  localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_CYCLES - 1);

  state_e      state, state_n;
  err_code_e   err_q, err_n;
  logic [2:0]  count, count_n;
  logic        is_alarm, is_alarm_n;
  logic [23:0] digits, digits_n;
  logic [7:0]  hours_n, minutes_n, seconds_n;
  logic        set_time_n, set_alarm_n, cmd_error_n;
  logic [31:0] tmo_cnt;
  logic        timeout_hit, is_digit, is_term, range_ok;
  logic [2:0]  need;

  bcd_time_range_check u_range (
    .digits   (digits),
    .is_alarm (is_alarm),
    .range_ok (range_ok)
  );

  assign need        = is_alarm ? 3'd4 : 3'd6;
  assign is_digit    = (rx_data >= ASCII_0) && (rx_data <= ASCII_9);
  assign is_term     = (rx_data == ASCII_CR) || (rx_data == ASCII_LF);
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (state != ST_IDLE) && (tmo_cnt == TIMEOUT_LAST);
  assign err_code    = err_q;
  assign busy        = (state != ST_IDLE);

  always_comb begin
    state_n     = state;
    count_n     = count;
    is_alarm_n  = is_alarm;
    digits_n    = digits;
    hours_n     = hours_bcd;
    minutes_n   = minutes_bcd;
    seconds_n   = seconds_bcd;
    set_time_n  = 1'b0;
    set_alarm_n = 1'b0;
    cmd_error_n = 1'b0;
    err_n       = err_q;
    // Framing errors outrank a same-cycle byte, which is simply dropped.
    if (framing_error) begin
      state_n     = ST_IDLE;
      cmd_error_n = 1'b1;
      err_n       = ERR_FRAME_TIMEOUT;
    end else if (rx_valid) begin
      case (state)
        ST_IDLE: begin
          if (rx_data == ASCII_T_UP || rx_data == ASCII_T_LO) begin
            state_n    = ST_DIGITS;
            is_alarm_n = 1'b0;
            count_n    = 3'd0;
          end else if (rx_data == ASCII_A_UP || rx_data == ASCII_A_LO) begin
            state_n    = ST_DIGITS;
            is_alarm_n = 1'b1;
            count_n    = 3'd0;
          end else if (!is_term && rx_data != ASCII_SPACE) begin
            cmd_error_n = 1'b1;
            err_n       = ERR_UNKNOWN_CMD;
          end
        end
        ST_DIGITS: begin
          if (is_digit) begin
            digits_n = {digits[19:0], rx_data[3:0]};
            count_n  = count + 3'd1;
            if (count + 3'd1 == need) state_n = ST_TERM;
          end else begin
            state_n     = ST_IDLE;
            cmd_error_n = 1'b1;
            err_n       = ERR_BAD_CHAR;
          end
        end
        ST_TERM: begin
          state_n = ST_IDLE;
          if (!is_term) begin
            cmd_error_n = 1'b1;
            err_n       = ERR_BAD_CHAR;
          end else if (!range_ok) begin
            cmd_error_n = 1'b1;
            err_n       = ERR_RANGE;
          end else if (is_alarm) begin
            hours_n     = digits[15:8];
            minutes_n   = digits[7:0];
            seconds_n   = 8'h00;
            set_alarm_n = 1'b1;
          end else begin
            hours_n    = digits[23:16];
            minutes_n  = digits[15:8];
            seconds_n  = digits[7:0];
            set_time_n = 1'b1;
          end
        end
        default: state_n = ST_IDLE;
      endcase
    end else if (timeout_hit) begin
      state_n     = ST_IDLE;
      cmd_error_n = 1'b1;
      err_n       = ERR_FRAME_TIMEOUT;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      count       <= 3'd0;
      is_alarm    <= 1'b0;
      digits      <= 24'h0;
      hours_bcd   <= 8'h00;
      minutes_bcd <= 8'h00;
      seconds_bcd <= 8'h00;
      set_time    <= 1'b0;
      set_alarm   <= 1'b0;
      cmd_error   <= 1'b0;
      err_q       <= ERR_UNKNOWN_CMD;
    end else begin
      state       <= state_n;
      count       <= count_n;
      is_alarm    <= is_alarm_n;
      digits      <= digits_n;
      hours_bcd   <= hours_n;
      minutes_bcd <= minutes_n;
      seconds_bcd <= seconds_n;
      set_time    <= set_time_n;
      set_alarm   <= set_alarm_n;
      cmd_error   <= cmd_error_n;
      err_q       <= err_n;
    end
  end

  // Inter-byte gap counter; only runs while a command is in progress.
  always_ff @(posedge clk) begin
    if (reset || rx_valid || state == ST_IDLE || timeout_hit) begin
      tmo_cnt <= 32'd0;
    end else begin
      tmo_cnt <= tmo_cnt + 32'd1;
    end
  end

endmodule
